apb2axi_tag_dir: RTL and testbench

Parametrised successor to the gateway transaction directory. It tracks up to ENTRIES outstanding APB-initiated AXI transactions through the lifecycle EMPTY → ALLOCATED → PENDING → COMPLETE → EMPTY. Relative to the first generation it adds:
- lowest-free-index tag allocation,
- true allocation-order issue,
- independent consume and inspect ports,
- detection of unexpected completions,
- a programmable per-entry completion timeout.

It sits between the APB register file, the AXI request FIFO manager and the completion queue.

---
 rtl/apb2axi_tag_dir_if.sv | 60 ++++++
 rtl/apb2axi_tag_dir.sv | 189 ++++++++++++++++++
 tb/tb_apb2axi_tag_dir.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_tag_dir_if.sv
// Bus bundle for the APB-to-AXI tag directory: allocate, issue, completion,
// consume, inspect and timeout/status signals.
interface apb2axi_tag_dir_if #(
    parameter int ENTRIES   = 8,
    parameter int PAYLOAD_W = 64,
    parameter int TIMEOUT_W = 16
);
    localparam int TAG_W = $clog2(ENTRIES);

    logic                 alloc_vld;
    logic                 alloc_rdy;
    logic [PAYLOAD_W-1:0] alloc_payload;
    logic [TAG_W-1:0]     alloc_tag;

    logic                 pop_vld;
    logic                 pop_rdy;
    logic [TAG_W-1:0]     pop_tag;
    logic [PAYLOAD_W-1:0] pop_payload;

    logic                 cpl_vld;
    logic                 cpl_rdy;
    logic [TAG_W-1:0]     cpl_tag;
    logic [1:0]           cpl_resp;
    logic [7:0]           cpl_beats;
    logic                 cpl_err;

    logic                 consume_vld;
    logic [TAG_W-1:0]     consume_tag;

    logic [TAG_W-1:0]     sel_tag;
    logic [1:0]           sel_state;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [1:0]           sel_resp;
    logic [7:0]           sel_beats;
    logic                 sel_err;

    logic [TIMEOUT_W-1:0] timeout_cycles;
    logic                 timeout_pulse;
    logic [TAG_W-1:0]     timeout_tag;
    logic                 cpl_unexp_pulse;
    logic [TAG_W:0]       occupancy;

    modport slave (
        input  alloc_vld, alloc_payload, pop_rdy,
        input  cpl_vld, cpl_tag, cpl_resp, cpl_beats, cpl_err,
        input  consume_vld, consume_tag, sel_tag, timeout_cycles,
        output alloc_rdy, alloc_tag, pop_vld, pop_tag, pop_payload, cpl_rdy,
        output sel_state, sel_payload, sel_resp, sel_beats, sel_err,
        output timeout_pulse, timeout_tag, cpl_unexp_pulse, occupancy
    );

    modport master (
        output alloc_vld, alloc_payload, pop_rdy,
        output cpl_vld, cpl_tag, cpl_resp, cpl_beats, cpl_err,
        output consume_vld, consume_tag, sel_tag, timeout_cycles,
        input  alloc_rdy, alloc_tag, pop_vld, pop_tag, pop_payload, cpl_rdy,
        input  sel_state, sel_payload, sel_resp, sel_beats, sel_err,
        input  timeout_pulse, timeout_tag, cpl_unexp_pulse, occupancy
    );
endinterface

// File: rtl/apb2axi_tag_dir.sv
// Transaction directory: per-entry EMPTY/ALLOCATED/PENDING/COMPLETE tracking with
// allocation-order issue queue, unexpected-completion detection and timeouts.
module apb2axi_tag_dir #(
    parameter int ENTRIES   = 8,
    parameter int PAYLOAD_W = 64,
    parameter int TIMEOUT_W = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    apb2axi_tag_dir_if.slave bus
);
    localparam int TAG_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ALLOC = 2'd1,
        ST_PEND  = 2'd2,
        ST_CPL   = 2'd3
    } state_e;

    state_e               state_q   [ENTRIES];
    state_e               state_d   [ENTRIES];
    logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
    logic [PAYLOAD_W-1:0] payload_d [ENTRIES];
    logic [1:0]           resp_q    [ENTRIES];
    logic [1:0]           resp_d    [ENTRIES];
    logic [7:0]           beats_q   [ENTRIES];
    logic [7:0]           beats_d   [ENTRIES];
    logic                 err_q     [ENTRIES];
    logic                 err_d     [ENTRIES];
    logic [TIMEOUT_W-1:0] timer_q   [ENTRIES];
    logic [TIMEOUT_W-1:0] timer_d   [ENTRIES];
    logic [TAG_W-1:0]     ord_q     [ENTRIES];
    logic [TAG_W-1:0]     ord_d     [ENTRIES];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   cnt_q, cnt_d, occ_q, occ_d;
    logic             tmo_pulse_q, tmo_pulse_d, unexp_q, unexp_d;
    logic [TAG_W-1:0] tmo_tag_q, tmo_tag_d;

    logic             free_any, tmo_any;
    logic [TAG_W-1:0] free_tag, tmo_tag, head_tag;
    logic             alloc_fire, pop_fire, cpl_fire, cpl_ok, cons_ok;

    assign head_tag   = ord_q[head_q];
    assign alloc_fire = bus.alloc_vld && free_any;
    assign pop_fire   = (cnt_q != '0) && bus.pop_rdy;
    assign cpl_fire   = bus.cpl_vld && presetn;
    assign cpl_ok     = cpl_fire && (state_q[bus.cpl_tag] == ST_PEND);
    assign cons_ok    = bus.consume_vld && (state_q[bus.consume_tag] == ST_CPL);

    always_comb begin : find_free
        free_any = 1'b0;
        free_tag = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_EMPTY) begin
                free_any = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    // A same-cycle completion to an eligible tag wins; that tag is not a timeout candidate.
    always_comb begin : find_timeout
        tmo_any = 1'b0;
        tmo_tag = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_PEND && bus.timeout_cycles != '0 &&
                timer_q[i] == bus.timeout_cycles &&
                !(cpl_fire && bus.cpl_tag == TAG_W'(i))) begin
                tmo_any = 1'b1;
                tmo_tag = TAG_W'(i);
            end
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        payload_d = payload_q;
        resp_d    = resp_q;
        beats_d   = beats_q;
        err_d     = err_q;
        timer_d   = timer_q;
        ord_d     = ord_q;
        head_d    = head_q;
        tail_d    = tail_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_PEND && timer_q[i] < bus.timeout_cycles) begin
                timer_d[i] = timer_q[i] + 1'b1;
            end
        end

        // All events below act on distinct tags, so their order here is immaterial.
        if (alloc_fire) begin
            state_d[free_tag]   = ST_ALLOC;
            payload_d[free_tag] = bus.alloc_payload;
            resp_d[free_tag]    = '0;
            beats_d[free_tag]   = '0;
            err_d[free_tag]     = 1'b0;
            timer_d[free_tag]   = '0;
            ord_d[tail_q]       = free_tag;
            tail_d              = tail_q + 1'b1;
        end
        if (pop_fire) begin
            state_d[head_tag] = ST_PEND;
            timer_d[head_tag] = '0;
            head_d            = head_q + 1'b1;
        end
        if (cpl_ok) begin
            state_d[bus.cpl_tag] = ST_CPL;
            resp_d[bus.cpl_tag]  = bus.cpl_resp;
            beats_d[bus.cpl_tag] = bus.cpl_beats;
            err_d[bus.cpl_tag]   = bus.cpl_err;
        end
        if (tmo_any) begin
            state_d[tmo_tag] = ST_CPL;
            resp_d[tmo_tag]  = 2'b10;
            beats_d[tmo_tag] = '0;
            err_d[tmo_tag]   = 1'b1;
        end
        if (cons_ok) begin
            state_d[bus.consume_tag]   = ST_EMPTY;
            payload_d[bus.consume_tag] = '0;
            resp_d[bus.consume_tag]    = '0;
            beats_d[bus.consume_tag]   = '0;
            err_d[bus.consume_tag]     = 1'b0;
            timer_d[bus.consume_tag]   = '0;
        end

        cnt_d       = cnt_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(pop_fire);
        occ_d       = occ_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(cons_ok);
        tmo_pulse_d = tmo_any;
        tmo_tag_d   = tmo_any ? tmo_tag : '0;
        unexp_d     = cpl_fire && !cpl_ok;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i]   <= ST_EMPTY;
                payload_q[i] <= '0;
                resp_q[i]    <= '0;
                beats_q[i]   <= '0;
                err_q[i]     <= 1'b0;
                timer_q[i]   <= '0;
                ord_q[i]     <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            occ_q       <= '0;
            tmo_pulse_q <= 1'b0;
            tmo_tag_q   <= '0;
            unexp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            resp_q      <= resp_d;
            beats_q     <= beats_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            ord_q       <= ord_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            tmo_pulse_q <= tmo_pulse_d;
            tmo_tag_q   <= tmo_tag_d;
            unexp_q     <= unexp_d;
        end
    end

    assign bus.alloc_rdy       = free_any;
    assign bus.alloc_tag       = free_tag;
    assign bus.pop_vld         = (cnt_q != '0);
    assign bus.pop_tag         = head_tag;
    assign bus.pop_payload     = payload_q[head_tag];
    assign bus.cpl_rdy         = presetn;
    assign bus.sel_state       = state_q[bus.sel_tag];
    assign bus.sel_payload     = payload_q[bus.sel_tag];
    assign bus.sel_resp        = resp_q[bus.sel_tag];
    assign bus.sel_beats       = beats_q[bus.sel_tag];
    assign bus.sel_err         = err_q[bus.sel_tag];
    assign bus.timeout_pulse   = tmo_pulse_q;
    assign bus.timeout_tag     = tmo_tag_q;
    assign bus.cpl_unexp_pulse = unexp_q;
    assign bus.occupancy       = occ_q;
endmodule

// File: tb/tb_apb2axi_tag_dir.sv
// Directed bench for apb2axi_tag_dir: a vector table for fill/complete/consume,
// then hand sequences for issue order, timeouts, completion races and async reset.
module tb_apb2axi_tag_dir;
    logic pclk;
    logic presetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    apb2axi_tag_dir_if #(.ENTRIES(8), .PAYLOAD_W(64), .TIMEOUT_W(16)) bus();

    apb2axi_tag_dir #(.ENTRIES(8), .PAYLOAD_W(64), .TIMEOUT_W(16)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        alloc;
        logic [15:0] pay;
        logic        pop;
        logic        cpl;
        logic [2:0]  ctag;
        logic [1:0]  cresp;
        logic [7:0]  cbeats;
        logic        cons;
        logic [2:0]  ntag;
        logic        e_rdy;
        logic [2:0]  e_atag;
        logic        e_pvld;
        logic [2:0]  e_ptag;
        logic [15:0] e_ppay;
        logic [3:0]  e_occ;
        logic        e_unexp;
        logic [1:0]  e_sst;
        logic [7:0]  e_sb;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic a, input logic [15:0] pay, input logic p,
        input logic c, input logic [2:0] ct, input logic [1:0] cr, input logic [7:0] cb,
        input logic n, input logic [2:0] nt,
        input logic rdy, input logic [2:0] at, input logic pv, input logic [2:0] pt,
        input logic [15:0] pp, input logic [3:0] oc, input logic ux,
        input logic [1:0] ss, input logic [7:0] sb);
        vec_t v;
        v.alloc = a; v.pay = pay; v.pop = p;
        v.cpl = c; v.ctag = ct; v.cresp = cr; v.cbeats = cb;
        v.cons = n; v.ntag = nt;
        v.e_rdy = rdy; v.e_atag = at; v.e_pvld = pv; v.e_ptag = pt;
        v.e_ppay = pp; v.e_occ = oc; v.e_unexp = ux; v.e_sst = ss; v.e_sb = sb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_vld     = 1'b0;
        bus.alloc_payload = '0;
        bus.pop_rdy       = 1'b0;
        bus.cpl_vld       = 1'b0;
        bus.cpl_tag       = '0;
        bus.cpl_resp      = '0;
        bus.cpl_beats     = '0;
        bus.cpl_err       = 1'b0;
        bus.consume_vld   = 1'b0;
        bus.consume_tag   = '0;
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        presetn = 1'b0;
        tick();
        tick();
        presetn = 1'b1;
        #1;
    endtask

    task automatic alloc_one(input logic [63:0] pay);
        bus.alloc_vld = 1'b1;
        bus.alloc_payload = pay;
        tick();
        bus.alloc_vld = 1'b0;
    endtask

    logic [2:0]  exp_ord [3] = '{3'd2, 3'd3, 3'd1};
    logic [15:0] exp_opy [3] = '{16'h202, 16'h203, 16'h204};

    initial begin
        int p_cnt;
        int p_cyc [2];
        logic [2:0] p_tag [2];

        // Table: fill all 8, reject a 9th, then pop/complete/consume and stray completions.
        vecs[0]  = mk(1,'h100,0, 0,0,0,0, 0,0,  1,1,1,0,'h100,1,0,1,0);
        vecs[1]  = mk(1,'h101,0, 0,0,0,0, 0,0,  1,2,1,0,'h100,2,0,1,0);
        vecs[2]  = mk(1,'h102,0, 0,0,0,0, 0,0,  1,3,1,0,'h100,3,0,1,0);
        vecs[3]  = mk(1,'h103,0, 0,0,0,0, 0,0,  1,4,1,0,'h100,4,0,1,0);
        vecs[4]  = mk(1,'h104,0, 0,0,0,0, 0,0,  1,5,1,0,'h100,5,0,1,0);
        vecs[5]  = mk(1,'h105,0, 0,0,0,0, 0,0,  1,6,1,0,'h100,6,0,1,0);
        vecs[6]  = mk(1,'h106,0, 0,0,0,0, 0,0,  1,7,1,0,'h100,7,0,1,0);
        vecs[7]  = mk(1,'h107,0, 0,0,0,0, 0,0,  0,0,1,0,'h100,8,0,1,0);
        vecs[8]  = mk(1,'h1FF,0, 0,0,0,0, 0,0,  0,0,1,0,'h100,8,0,1,0);
        vecs[9]  = mk(0,0,1,     0,0,0,0, 0,0,  0,0,1,1,'h101,8,0,2,0);
        vecs[10] = mk(0,0,0,     1,0,0,4, 0,0,  0,0,1,1,'h101,8,0,3,4);
        vecs[11] = mk(0,0,0,     0,0,0,0, 1,0,  1,0,1,1,'h101,7,0,0,0);
        vecs[12] = mk(0,0,0,     1,3,1,9, 0,0,  1,0,1,1,'h101,7,1,0,0);
        vecs[13] = mk(0,0,0,     0,0,0,0, 0,0,  1,0,1,1,'h101,7,0,0,0);
        vecs[14] = mk(0,0,0,     1,0,2,5, 0,0,  1,0,1,1,'h101,7,1,0,0);
        vecs[15] = mk(0,0,0,     0,0,0,0, 1,2,  1,0,1,1,'h101,7,0,0,0);

        idle_inputs();
        bus.sel_tag = '0;
        bus.timeout_cycles = '0;
        presetn = 1'b0;
        #2;
        chk("rst.alloc_rdy", bus.alloc_rdy, 1);
        chk("rst.alloc_tag", bus.alloc_tag, 0);
        chk("rst.pop_vld", bus.pop_vld, 0);
        chk("rst.cpl_rdy", bus.cpl_rdy, 0);
        chk("rst.occupancy", bus.occupancy, 0);
        chk("rst.tmo_pulse", bus.timeout_pulse, 0);
        chk("rst.tmo_tag", bus.timeout_tag, 0);
        chk("rst.unexp", bus.cpl_unexp_pulse, 0);
        chk("rst.sel_state", bus.sel_state, 0);
        chk("rst.sel_payload", bus.sel_payload, 0);
        do_reset();
        chk("rst.cpl_rdy_hi", bus.cpl_rdy, 1);

        for (int i = 0; i < 16; i++) begin
            bus.alloc_vld     = vecs[i].alloc;
            bus.alloc_payload = 64'(vecs[i].pay);
            bus.pop_rdy       = vecs[i].pop;
            bus.cpl_vld       = vecs[i].cpl;
            bus.cpl_tag       = vecs[i].ctag;
            bus.cpl_resp      = vecs[i].cresp;
            bus.cpl_beats     = vecs[i].cbeats;
            bus.consume_vld   = vecs[i].cons;
            bus.consume_tag   = vecs[i].ntag;
            tick();
            chk($sformatf("v%0d.alloc_rdy", i), bus.alloc_rdy, vecs[i].e_rdy);
            chk($sformatf("v%0d.alloc_tag", i), bus.alloc_tag, vecs[i].e_atag);
            chk($sformatf("v%0d.pop_vld", i), bus.pop_vld, vecs[i].e_pvld);
            chk($sformatf("v%0d.pop_tag", i), bus.pop_tag, vecs[i].e_ptag);
            chk($sformatf("v%0d.pop_payload", i), bus.pop_payload, 64'(vecs[i].e_ppay));
            chk($sformatf("v%0d.occupancy", i), bus.occupancy, vecs[i].e_occ);
            chk($sformatf("v%0d.unexp", i), bus.cpl_unexp_pulse, vecs[i].e_unexp);
            chk($sformatf("v%0d.sel_state", i), bus.sel_state, vecs[i].e_sst);
            chk($sformatf("v%0d.sel_beats", i), bus.sel_beats, vecs[i].e_sb);
        end
        idle_inputs();
        bus.sel_tag = 3'd3;
        #1;
        chk("tbl.t3_state", bus.sel_state, 1);
        chk("tbl.t3_payload", bus.sel_payload, 64'h103);
        chk("tbl.t3_resp", bus.sel_resp, 0);
        bus.sel_tag = 3'd7;
        #1;
        chk("tbl.t7_payload", bus.sel_payload, 64'h107);
        bus.sel_tag = 3'd0;
        #1;
        chk("tbl.t0_payload", bus.sel_payload, 0);

        // Issue order with a recycled tag, and a completion racing its own pop.
        do_reset();
        alloc_one(64'h200);
        alloc_one(64'h201);
        alloc_one(64'h202);
        chk("ord.occ3", bus.occupancy, 3);
        chk("ord.head0", bus.pop_tag, 0);
        bus.pop_rdy = 1'b1;
        bus.cpl_vld = 1'b1;
        bus.cpl_tag = 3'd0;
        tick();
        chk("ord.pop_cpl_unexp", bus.cpl_unexp_pulse, 1);
        chk("ord.t0_pend", bus.sel_state, 2);
        chk("ord.head1", bus.pop_tag, 1);
        bus.cpl_vld = 1'b0;
        tick();
        chk("ord.unexp_clr", bus.cpl_unexp_pulse, 0);
        chk("ord.head2", bus.pop_tag, 2);
        bus.pop_rdy   = 1'b0;
        bus.cpl_vld   = 1'b1;
        bus.cpl_tag   = 3'd1;
        bus.cpl_resp  = 2'd3;
        bus.cpl_beats = 8'd2;
        bus.cpl_err   = 1'b1;
        tick();
        bus.cpl_vld = 1'b0;
        bus.sel_tag = 3'd1;
        #1;
        chk("ord.t1_state", bus.sel_state, 3);
        chk("ord.t1_resp", bus.sel_resp, 3);
        chk("ord.t1_beats", bus.sel_beats, 2);
        chk("ord.t1_err", bus.sel_err, 1);
        chk("ord.alloc_tag3", bus.alloc_tag, 3);
        bus.consume_vld   = 1'b1;
        bus.consume_tag   = 3'd1;
        bus.alloc_vld     = 1'b1;
        bus.alloc_payload = 64'h203;
        tick();
        bus.consume_vld = 1'b0;
        bus.alloc_vld   = 1'b0;
        chk("ord.occ_same", bus.occupancy, 3);
        chk("ord.alloc_tag1", bus.alloc_tag, 1);
        chk("ord.t1_empty", bus.sel_state, 0);
        alloc_one(64'h204);
        chk("ord.occ4", bus.occupancy, 4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ord.pop%0d_vld", k), bus.pop_vld, 1);
            chk($sformatf("ord.pop%0d_tag", k), bus.pop_tag, exp_ord[k]);
            chk($sformatf("ord.pop%0d_pay", k), bus.pop_payload, 64'(exp_opy[k]));
            bus.pop_rdy = 1'b1;
            tick();
        end
        bus.pop_rdy = 1'b0;
        chk("ord.drained", bus.pop_vld, 0);

        // Two timeouts that become eligible on consecutive cycles.
        do_reset();
        bus.timeout_cycles = 16'd5;
        bus.sel_tag = 3'd0;
        alloc_one(64'h300);
        alloc_one(64'h301);
        bus.pop_rdy = 1'b1;
        tick();
        bus.pop_rdy = 1'b1;
        tick();
        bus.pop_rdy = 1'b0;
        p_cnt = 0;
        p_cyc[0] = 0; p_cyc[1] = 0;
        p_tag[0] = '0; p_tag[1] = '0;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (k == 6) chk("tmo.t0_still_pend", bus.sel_state, 2);
            if (k == 7) chk("tmo.t0_cpl_at_T2", bus.sel_state, 3);
            if (bus.timeout_pulse) begin
                if (p_cnt < 2) begin
                    p_cyc[p_cnt] = k;
                    p_tag[p_cnt] = bus.timeout_tag;
                end
                p_cnt++;
            end
        end
        chk("tmo.pulse_count", 64'(p_cnt), 2);
        chk("tmo.first_tag", p_tag[0], 0);
        chk("tmo.second_tag", p_tag[1], 1);
        chk("tmo.consecutive", 64'(p_cyc[1] - p_cyc[0]), 1);
        for (int t = 0; t < 2; t++) begin
            bus.sel_tag = 3'(t);
            #1;
            chk($sformatf("tmo.t%0d_state", t), bus.sel_state, 3);
            chk($sformatf("tmo.t%0d_resp", t), bus.sel_resp, 2);
            chk($sformatf("tmo.t%0d_err", t), bus.sel_err, 1);
            chk($sformatf("tmo.t%0d_beats", t), bus.sel_beats, 0);
        end

        // Completion arriving in the same cycle the timeout would fire.
        do_reset();
        bus.timeout_cycles = 16'd3;
        bus.sel_tag = 3'd0;
        alloc_one(64'h400);
        bus.pop_rdy = 1'b1;
        tick();
        bus.pop_rdy = 1'b0;
        tick();
        tick();
        tick();
        chk("race.pend", bus.sel_state, 2);
        chk("race.no_pulse_yet", bus.timeout_pulse, 0);
        bus.cpl_vld   = 1'b1;
        bus.cpl_tag   = 3'd0;
        bus.cpl_resp  = 2'd1;
        bus.cpl_beats = 8'd7;
        bus.cpl_err   = 1'b0;
        tick();
        bus.cpl_vld = 1'b0;
        chk("race.state", bus.sel_state, 3);
        chk("race.resp", bus.sel_resp, 1);
        chk("race.beats", bus.sel_beats, 7);
        chk("race.err", bus.sel_err, 0);
        chk("race.no_tmo", bus.timeout_pulse, 0);
        chk("race.no_unexp", bus.cpl_unexp_pulse, 0);
        tick();
        chk("race.no_tmo_late", bus.timeout_pulse, 0);

        // Asynchronous reset with three entries in flight.
        do_reset();
        bus.timeout_cycles = '0;
        alloc_one(64'h500);
        alloc_one(64'h501);
        alloc_one(64'h502);
        bus.pop_rdy = 1'b1;
        tick();
        tick();
        tick();
        bus.pop_rdy = 1'b0;
        bus.sel_tag = 3'd1;
        #1;
        chk("arst.pre_state", bus.sel_state, 2);
        chk("arst.pre_occ", bus.occupancy, 3);
        #1;
        presetn = 1'b0;
        #1;
        chk("arst.alloc_rdy", bus.alloc_rdy, 1);
        chk("arst.alloc_tag", bus.alloc_tag, 0);
        chk("arst.pop_vld", bus.pop_vld, 0);
        chk("arst.cpl_rdy", bus.cpl_rdy, 0);
        chk("arst.occ", bus.occupancy, 0);
        chk("arst.sel_state", bus.sel_state, 0);
        chk("arst.sel_payload", bus.sel_payload, 0);
        chk("arst.tmo_pulse", bus.timeout_pulse, 0);
        chk("arst.unexp", bus.cpl_unexp_pulse, 0);
        tick();
        presetn = 1'b1;
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
